// File: rtl/rq_scheduler.sv
// Request scheduler for an N-storey car: latches hall and car calls, clears them at the
// served floor with the door open, and commits the car to an idle/up/down sweep direction.
module rq_scheduler #(
   parameter int FLOORS = 4,
   parameter int CNT_W  = $clog2(FLOORS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FLOORS-1:0] up_btn,
   input  logic [FLOORS-1:0] down_btn,
   input  logic [FLOORS-1:0] car_btn,
   input  logic [FLOORS-1:0] position,
   input  logic              door_open,
   input  logic [FLOORS-1:0] lock,
   output logic [FLOORS-1:0] up_req,
   output logic [FLOORS-1:0] down_req,
   output logic [FLOORS-1:0] car_req,
   output logic [1:0]        dir,
   output logic              up_need,
   output logic              down_need,
   output logic              stop_here,
   output logic [CNT_W-1:0]  pending_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10
   } dir_t;

   localparam logic [FLOORS-1:0] UP_OK   = {1'b0, {(FLOORS-1){1'b1}}};
   localparam logic [FLOORS-1:0] DOWN_OK = {{(FLOORS-1){1'b1}}, 1'b0};

   dir_t              state_reg, state_next;
   logic [FLOORS-1:0] last_pos_reg;
   logic [FLOORS-1:0] up_req_reg, down_req_reg, car_req_reg;
   logic [FLOORS-1:0] up_req_next, down_req_next, car_req_next;
   logic [FLOORS-1:0] all_req, below_mask, above_mask;
   logic [FLOORS-1:0] clr_up, clr_down, clr_car;
   logic              pos_nz, pos_onehot, door_clr;
   logic              above_any, below_any, here_any;
   logic [CNT_W-1:0]  cnt_next;

   assign pos_nz     = |position;
   assign pos_onehot = pos_nz && ((position & (position - FLOORS'(1))) == '0);
   assign door_clr   = door_open && pos_nz;

   // last_pos_reg is always one-hot, so subtracting one yields every floor below it
   assign all_req    = up_req_reg | down_req_reg | car_req_reg;
   assign below_mask = last_pos_reg - FLOORS'(1);
   assign above_mask = ~(below_mask | last_pos_reg);
   assign above_any  = |(all_req & above_mask);
   assign below_any  = |(all_req & below_mask);
   assign here_any   = |(all_req & last_pos_reg);

   always_comb begin
      clr_car  = '0;
      clr_up   = '0;
      clr_down = '0;
      if (door_clr) begin
         clr_car = position;
         unique case (state_reg)
            UP: begin
               clr_up   = position;
               clr_down = above_any ? '0 : position;
            end
            DOWN: begin
               clr_down = position;
               clr_up   = below_any ? '0 : position;
            end
            default: begin
               clr_up   = position;
               clr_down = position;
            end
         endcase
      end
   end

   // Per floor: lock beats clear, clear beats a press, a press beats holding
   generate
      for (genvar gi = 0; gi < FLOORS; gi++) begin : g_floor
         assign up_req_next[gi]   = ~lock[gi] & ~clr_up[gi]
                                    & (up_req_reg[gi] | (up_btn[gi] & UP_OK[gi]));
         assign down_req_next[gi] = ~lock[gi] & ~clr_down[gi]
                                    & (down_req_reg[gi] | (down_btn[gi] & DOWN_OK[gi]));
         assign car_req_next[gi]  = ~lock[gi] & ~clr_car[gi]
                                    & (car_req_reg[gi] | car_btn[gi]);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_req_reg   <= '0;
         down_req_reg <= '0;
         car_req_reg  <= '0;
         last_pos_reg <= FLOORS'(1);
         state_reg    <= IDLE;
      end else begin
         up_req_reg   <= up_req_next;
         down_req_reg <= down_req_next;
         car_req_reg  <= car_req_next;
         if (pos_onehot)
            last_pos_reg <= position;
         state_reg    <= state_next;
      end
   end

   // Direction only re-evaluates while the car sits at a floor
   always_comb begin
      state_next = state_reg;
      if (pos_nz) begin
         unique case (state_reg)
            DOWN:    state_next = below_any ? DOWN : (above_any ? UP : IDLE);
            default: state_next = above_any ? UP : (below_any ? DOWN : IDLE);
         endcase
      end
   end

   always_comb begin
      cnt_next = '0;
      for (int i = 0; i < FLOORS; i++)
         cnt_next = cnt_next + CNT_W'(all_req[i]);
   end

   assign up_req      = up_req_reg;
   assign down_req    = down_req_reg;
   assign car_req     = car_req_reg;
   assign dir         = state_reg;
   assign up_need     = (state_reg == UP);
   assign down_need   = (state_reg == DOWN);
   assign pending_cnt = cnt_next;
   assign stop_here   = (|(car_req_reg & last_pos_reg))
                        | ((state_reg != DOWN) && (|(up_req_reg & last_pos_reg)))
                        | ((state_reg != UP) && (|(down_req_reg & last_pos_reg)))
                        | ((state_reg == UP) && !above_any && here_any)
                        | ((state_reg == DOWN) && !below_any && here_any);

endmodule
